// File: rtl/rollingsum_pkg.sv
// rtl/rollingsum_pkg.sv - shared types and width/clamp helpers for the rolling-window summer
package rollingsum_pkg;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    function automatic int s_width(input int d_w, input int max_len);
        return d_w + $clog2(max_len);
    endfunction

    function automatic int len_width(input int max_len);
        return $clog2(max_len) + 1;
    endfunction

    // Window length actually used: 0 behaves as 1, anything above the buffer depth as the depth
    function automatic int unsigned neff_clamp(input int unsigned len, input int unsigned max_len);
        if (len < 1)
            return 1;
        else if (len > max_len)
            return max_len;
        else
            return len;
    endfunction

endpackage

// File: rtl/rollingsum_mc_if.sv
// rtl/rollingsum_mc_if.sv - sample/control/result bundle; ROLLINGSUM_THRESH_EN adds thresh/over_thr
interface rollingsum_mc_if #(
    parameter int N_CH    = 2,
    parameter int D_W     = 12,
    parameter int MAX_LEN = 256,
    parameter int PAUSE_W = 16
);
    localparam int LEN_W = rollingsum_pkg::len_width(MAX_LEN);
    localparam int S_W   = rollingsum_pkg::s_width(D_W, MAX_LEN);

    logic [N_CH*D_W-1:0] d_in;
    logic                trig;
    logic                pause;
    logic                pause_ovr;
    logic [LEN_W-1:0]    sum_len;
    logic [PAUSE_W-1:0]  pause_len;
    logic [N_CH*S_W-1:0] sum_out;
    logic                valid;
    logic [1:0]          state_o;
`ifdef ROLLINGSUM_THRESH_EN
    logic [S_W-1:0]      thresh;
    logic [N_CH-1:0]     over_thr;

    modport master (output d_in, trig, pause, pause_ovr, sum_len, pause_len, thresh,
                    input  sum_out, valid, state_o, over_thr);
    modport slave  (input  d_in, trig, pause, pause_ovr, sum_len, pause_len, thresh,
                    output sum_out, valid, state_o, over_thr);
`else
    modport master (output d_in, trig, pause, pause_ovr, sum_len, pause_len,
                    input  sum_out, valid, state_o);
    modport slave  (input  d_in, trig, pause, pause_ovr, sum_len, pause_len,
                    output sum_out, valid, state_o);
`endif

endinterface

// File: rtl/rollingsum_chan.sv
// rtl/rollingsum_chan.sv - one channel: input register, circular sample buffer, running sum (ROLLINGSUM_THRESH_EN adds over_thr)
module rollingsum_chan #(
    parameter int D_W     = 12,
    parameter int MAX_LEN = 256,
    parameter int S_W     = 20,
    parameter int PTR_W   = $clog2(MAX_LEN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [D_W-1:0]   d_in,
    input  logic             we,
    input  logic             clr,
    input  logic             sub_en,
    input  logic [PTR_W-1:0] wr_ptr,
    input  logic [PTR_W-1:0] rd_ptr,
`ifdef ROLLINGSUM_THRESH_EN
    input  logic [S_W-1:0]   thresh,
    input  logic             valid_nxt,
    output logic             over_thr,
`endif
    output logic [S_W-1:0]   sum
);

    logic [D_W-1:0] mem [MAX_LEN];
    logic [D_W-1:0] d_q;
    logic [D_W-1:0] old;
    logic [S_W-1:0] sum_nxt;

    // Combinational read sees the value before this cycle's write lands
    assign old = mem[rd_ptr];

    always_comb begin
        sum_nxt = sum;
        if (clr)
            sum_nxt = '0;
        else if (we)
            sum_nxt = sum + S_W'(d_q) - (sub_en ? S_W'(old) : '0);
    end

    always_ff @(posedge clk) begin
        if (we)
            mem[wr_ptr] <= d_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q <= '0;
            sum <= '0;
        end else begin
            d_q <= d_in;
            sum <= sum_nxt;
        end
    end

`ifdef ROLLINGSUM_THRESH_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            over_thr <= 1'b0;
        else
            over_thr <= valid_nxt && (sum_nxt > thresh);
    end
`endif

endmodule

// File: rtl/rollingsum_mc.sv
// rtl/rollingsum_mc.sv - multi-channel rolling-window summer top: shared FSM/pointers, N_CH channels (option ROLLINGSUM_THRESH_EN)
module rollingsum_mc
    import rollingsum_pkg::*;
#(
    parameter int N_CH    = 2,
    parameter int D_W     = 12,
    parameter int MAX_LEN = 256,
    parameter int PAUSE_W = 16,
    parameter int LEN_W   = len_width(MAX_LEN),
    parameter int S_W     = s_width(D_W, MAX_LEN)
) (
    input logic            clk,
    input logic            rst_n,
    rollingsum_mc_if.slave bus
);

    localparam int PTR_W = $clog2(MAX_LEN);

    state_t             state;
    logic [LEN_W-1:0]   neff_q;
    logic [LEN_W-1:0]   fill_cnt;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PAUSE_W-1:0] pcnt;
    logic               valid;

    logic [LEN_W-1:0]   neff_in;
    logic [LEN_W-1:0]   fill_inc;
    logic [PTR_W-1:0]   rd_ptr;
    logic               go_pause;
    logic               chg;
    logic               pause_done;
    logic               run_path;
    logic               we;
    logic               clr;
    logic               sub_en;
    logic               valid_nxt;

    always_comb begin
        neff_in    = LEN_W'(neff_clamp(32'(bus.sum_len), 32'(MAX_LEN)));
        fill_inc   = fill_cnt + LEN_W'(1);
        rd_ptr     = wr_ptr - neff_q[PTR_W-1:0];
        go_pause   = bus.pause_ovr || (bus.trig && bus.pause && (bus.pause_len != '0));
        chg        = (neff_in != neff_q);
        pause_done = (pcnt <= PAUSE_W'(1)) && !bus.pause_ovr;
        // Pause entry beats a window change; the new window is picked up at the refill
        run_path   = (state != ST_PAUSE) && !go_pause && !chg;
        we         = run_path;
        clr        = ((state != ST_PAUSE) && !go_pause && chg) ||
                     ((state == ST_PAUSE) && pause_done);
        sub_en     = (fill_cnt >= neff_q);
        valid_nxt  = run_path && ((state == ST_RUN) || (fill_inc >= neff_q));
    end

    // neff_q resets to 0 (never a legal window) so the first active cycle starts a clean fill
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_FILL;
            neff_q   <= '0;
            fill_cnt <= '0;
            wr_ptr   <= '0;
            pcnt     <= '0;
            valid    <= 1'b0;
        end else begin
            valid  <= valid_nxt;
            neff_q <= neff_in;
            case (state)
                ST_FILL, ST_RUN: begin
                    if (go_pause) begin
                        state <= ST_PAUSE;
                        pcnt  <= bus.pause_len;
                    end else if (chg) begin
                        state    <= ST_FILL;
                        fill_cnt <= '0;
                    end else begin
                        wr_ptr <= wr_ptr + PTR_W'(1);
                        if (state == ST_FILL) begin
                            fill_cnt <= fill_inc;
                            if (fill_inc >= neff_q)
                                state <= ST_RUN;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (pcnt != '0)
                        pcnt <= pcnt - PAUSE_W'(1);
                    if (pause_done) begin
                        state    <= ST_FILL;
                        fill_cnt <= '0;
                    end
                end
                default: state <= ST_FILL;
            endcase
        end
    end

    assign bus.valid   = valid;
    assign bus.state_o = state;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic [S_W-1:0] sum_c;

        rollingsum_chan #(
            .D_W    (D_W),
            .MAX_LEN(MAX_LEN),
            .S_W    (S_W),
            .PTR_W  (PTR_W)
        ) u_chan (
            .clk      (clk),
            .rst_n    (rst_n),
            .d_in     (bus.d_in[c*D_W +: D_W]),
            .we       (we),
            .clr      (clr),
            .sub_en   (sub_en),
            .wr_ptr   (wr_ptr),
            .rd_ptr   (rd_ptr),
`ifdef ROLLINGSUM_THRESH_EN
            .thresh   (bus.thresh),
            .valid_nxt(valid_nxt),
            .over_thr (bus.over_thr[c]),
`endif
            .sum      (sum_c)
        );

        assign bus.sum_out[c*S_W +: S_W] = sum_c;
    end

endmodule
